// File: rtl/dma_ahb_mst.sv
// Single-channel DMA request port to AHB-Lite master: SINGLE NONSEQ transfers,
// address/data pipelining, two-cycle ERROR handling with in-order responses.
module dma_ahb_mst (
  input  logic        hclk,
  input  logic        hrst_n,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_vld,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] m_haddr,
  output logic [1:0]  m_htrans,
  output logic        m_hwrite,
  output logic [2:0]  m_hsize,
  output logic [2:0]  m_hburst,
  output logic [3:0]  m_hprot,
  output logic [31:0] m_hwdata,
  input  logic [31:0] m_hrdata,
  input  logic        m_hready,
  input  logic [1:0]  m_hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic        addr_vld;
  logic        data_vld;
  logic        data_write;
  logic        err_hold;
  logic        cancel_pend;
  logic [31:0] addr_wdata;

  logic        accept;
  logic        addr_done;
  logic        data_done;
  logic        bus_err;
  logic        first_err;
  logic [1:0]  eff_size;
  logic [31:0] aligned_addr;

  assign m_hburst  = 3'b000;
  assign m_hprot   = 4'b0011;

  assign req_rdy   = (~addr_vld | m_hready) & ~err_hold;
  assign accept    = req_vld & req_rdy;
  assign bus_err   = (m_hresp != 2'b00);
  assign addr_done = addr_vld & m_hready;
  assign data_done = data_vld & m_hready;
  // First ERROR cycle is the only time a response is non-OKAY while HREADY is low
  assign first_err = data_vld & ~m_hready & bus_err & ~err_hold;

  always_comb begin
    eff_size     = (req_size == 2'b11) ? 2'b10 : req_size;
    aligned_addr = req_addr;
    case (eff_size)
      2'b01:   aligned_addr = {req_addr[31:1], 1'b0};
      2'b10:   aligned_addr = {req_addr[31:2], 2'b00};
      default: aligned_addr = req_addr;
    endcase
  end

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      addr_vld    <= 1'b0;
      data_vld    <= 1'b0;
      data_write  <= 1'b0;
      err_hold    <= 1'b0;
      cancel_pend <= 1'b0;
      addr_wdata  <= 32'd0;
      m_htrans    <= HTRANS_IDLE;
      m_haddr     <= 32'd0;
      m_hwrite    <= 1'b0;
      m_hsize     <= 3'd0;
      m_hwdata    <= 32'd0;
      rsp_vld     <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= 32'd0;
    end else begin
      rsp_vld   <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;

      // A request accepted in the same cycle as the first ERROR is cancelled too,
      // so the bus still goes IDLE and the request still gets exactly one response.
      if (first_err) begin
        addr_vld    <= 1'b0;
        m_htrans    <= HTRANS_IDLE;
        err_hold    <= 1'b1;
        cancel_pend <= addr_vld | accept;
      end else if (accept) begin
        addr_vld   <= 1'b1;
        m_htrans   <= HTRANS_NONSEQ;
        m_haddr    <= aligned_addr;
        m_hsize    <= {1'b0, eff_size};
        m_hwrite   <= req_write;
        addr_wdata <= req_wdata;
      end else if (addr_done) begin
        addr_vld <= 1'b0;
        m_htrans <= HTRANS_IDLE;
      end

      if (addr_done) begin
        data_vld   <= 1'b1;
        data_write <= m_hwrite;
        m_hwdata   <= addr_wdata;
      end else if (data_done) begin
        data_vld <= 1'b0;
      end

      if (data_done) begin
        rsp_vld   <= 1'b1;
        rsp_err   <= bus_err;
        rsp_rdata <= (bus_err | data_write) ? 32'd0 : m_hrdata;
      end else if (cancel_pend & ~data_vld) begin
        rsp_vld     <= 1'b1;
        rsp_err     <= 1'b1;
        cancel_pend <= 1'b0;
      end

      if (err_hold & rsp_vld & rsp_err & ~cancel_pend & ~data_vld)
        err_hold <= 1'b0;
    end
  end

endmodule

// File: doc/dma_ahb_mst.md
DMA_AHB_MST -- requirements
Module: dma_ahb_mst

Interface
REQ-001 SHALL provide the ports below; reset hrst_n, asynchronous, active-low; clock hclk.
REQ-002 hclk  in  1  AHB clock; all state on rising edge.
REQ-003 hrst_n  in  1  asynchronous active-low reset.
REQ-004 req_vld  in  1  channel transfer request valid.
REQ-005 req_rdy  out  1  request accepted when req_vld & req_rdy at rising edge.
REQ-006 req_write  in  1  1 = write, 0 = read.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_size  in  2  00 byte, 01 halfword, 10 word; 11 reserved.
REQ-009 req_wdata  in  32  write data, lane-aligned by requester.
REQ-010 rsp_vld  out  1  one-cycle completion pulse, one per accepted request, in order.
REQ-011 rsp_rdata  out  32  read data; 0 for writes and errored transfers.
REQ-012 rsp_err  out  1  qualifies rsp_vld; 1 = bus error or cancelled.
REQ-013 m_haddr/m_htrans[1:0]/m_hwrite/m_hsize[2:0]  out  AHB address phase, all registered.
REQ-014 m_hburst  out  3  constant 3'b000 (SINGLE); m_hprot  out  4  constant 4'b0011.
REQ-015 m_hwdata  out  32  registered data-phase write data.
REQ-016 m_hrdata in 32, m_hready in 1, m_hresp in 2  AHB slave response.

Function
REQ-017 Only NONSEQ (2'b10) and IDLE (2'b00) SHALL be driven; never SEQ or BUSY.
REQ-018 Address slot: addr_vld flag; req_rdy = (~addr_vld | m_hready) & ~err_hold, combinational.
REQ-019 Accept at edge T: cycle T+1 drives m_htrans=NONSEQ, m_haddr=req_addr with low bits cleared per size (halfword [0]=0, word [1:0]=0), m_hsize={1'b0,req_size}, m_hwrite=req_write.
REQ-020 req_size=11 SHALL be issued as word.
REQ-021 Address phase completes at edge with m_hready=1; transfer then enters data phase; m_hwdata = captured req_wdata for whole data phase, held through wait states.
REQ-022 Pipelining: new request MAY be accepted at same edge address phase completes -> back-to-back NONSEQ, one transfer per cycle at zero wait states.
REQ-023 No accept that cycle -> m_htrans=IDLE next cycle; m_haddr/m_hwrite/m_hsize hold last values.
REQ-024 Data phase completes at edge with m_hready=1 and m_hresp=00: rsp_vld=1 next cycle, rsp_err=0, rsp_rdata=m_hrdata (read) or 0 (write).
REQ-025 Latency, zero waits: accept edge T -> address cycle T+1 -> data cycle T+2 -> rsp_vld cycle T+3. Each wait state adds one cycle.
REQ-026 Error: m_hresp!=00 with m_hready=0 (first ERROR cycle) -> master SHALL drive m_htrans=IDLE next cycle, cancelling any pending address phase; err_hold=1.
REQ-027 At the second ERROR cycle (m_hready=1): errored transfer reported rsp_vld=1, rsp_err=1; a cancelled pending transfer reported rsp_vld=1, rsp_err=1 one cycle later; order preserved.
REQ-028 err_hold clears after last error response is issued; req_rdy low throughout.
REQ-029 m_hresp 2'b10/2'b11 (RETRY/SPLIT) SHALL be treated as ERROR.
REQ-030 At most two outstanding transfers (one address, one data); rsp_vld never exceeds one per cycle.

Reset
REQ-031 While hrst_n=0: m_htrans=IDLE, m_haddr=0, m_hwrite=0, m_hsize=0, m_hwdata=0, rsp_vld=0, rsp_err=0, rsp_rdata=0, addr_vld=0, err_hold=0; req_rdy=1 after release.
REQ-032 Reset mid-transfer SHALL abandon all outstanding transfers without rsp_vld; first cycle after release drives IDLE.

Verification
REQ-033 Single read 0x4000_0330 word, m_hready=1, m_hrdata=0x0000_0001 -> NONSEQ at T+1, rsp_vld at T+3, rsp_rdata=0x1, rsp_err=0.
REQ-034 Four back-to-back word writes, zero waits -> four consecutive NONSEQ cycles, m_hwdata one cycle behind each address, four rsp_vld pulses consecutive.
REQ-035 Write with 3 wait states -> m_hwdata held 4 cycles, req_rdy low while addr_vld set, rsp_vld at T+6.
REQ-036 Read with ERROR while second request in address phase -> m_htrans=IDLE after first ERROR cycle, two rsp_vld with rsp_err=1 in order, req_rdy low until done.
REQ-037 Halfword request addr 0x...0333 -> m_haddr=0x...0332, m_hsize=3'b001; req_size=11 -> m_hsize=3'b010.
REQ-038 hrst_n asserted during data phase -> no rsp_vld, all outputs at reset values, next request after release completes normally.
